jstk_poll_ctrl: RTL

JSTK_POLL_CTRL -- requirements
Module: jstk_poll_ctrl

---
 rtl/jstk_poll_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/jstk_poll_ctrl.sv
// Joystick poll controller: issues a five-byte frame to an SPI byte engine every POLL_CYCLES.
// Optional macro JSTK_LED_CMD_EN places {6'b100000, LED} in the command byte instead of 8'h00.
module jstk_poll_ctrl #(
  parameter int POLL_CYCLES  = 3000,
  parameter int SS_SETUP     = 2,
  parameter int BYTE_GAP     = 1,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       EN,
  input  logic [1:0] LED,
  output logic       SND_REC,
  output logic [7:0] DIN,
  input  logic       BUSY,
  input  logic [7:0] DOUT,
  output logic       SS,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic [2:0] BTN,
  output logic       DATA_VALID,
  output logic       ERR,
  output logic       ACTIVE
);

  localparam int PW   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TMAX = (BUSY_TIMEOUT > SS_SETUP) ?
                        ((BUSY_TIMEOUT > BYTE_GAP) ? BUSY_TIMEOUT : BYTE_GAP) :
                        ((SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] SETUP_LAST = TW'(SS_SETUP - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(BYTE_GAP - 1);
  // WAIT_HI is entered one cycle after REQ, so the timeout fires one count early
  localparam logic [TW-1:0] TMO_LAST   = TW'(BUSY_TIMEOUT - 2);

  typedef enum logic [2:0] {
    IDLE, SETUP, REQ, WAIT_HI, WAIT_LO, GAP, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] poll_q;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh0_q, sh2_q;
  logic [1:0]    sh1_q, sh3_q;
  logic [9:0]    x_q, y_q;
  logic [2:0]    btn_q;
  logic          dv_q, err_q;
  logic          tick, frame_ok, tmo_hit;
  logic          snd_rec, ss_n;
  logic [7:0]    din;
  logic [7:0]    byte0_req, byte0_hold;

  assign tick     = (poll_q == '0);
  assign frame_ok = (state_q == WAIT_LO) && !BUSY && (idx_q == 3'd4);
  assign tmo_hit  = (state_q == WAIT_HI) && !BUSY && (tmr_q == TMO_LAST);

`ifdef JSTK_LED_CMD_EN
  logic [1:0] led_q;

  always_ff @(posedge CLK) begin
    if ((state_q == REQ) && (idx_q == 3'd0)) led_q <= LED;
  end

  // REQ drives the live LED value; WAIT_HI repeats the value sampled in REQ
  assign byte0_req  = {6'b100000, LED};
  assign byte0_hold = {6'b100000, led_q};
`else
  logic unused_led;
  assign unused_led = ^LED;
  assign byte0_req  = 8'h00;
  assign byte0_hold = 8'h00;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      poll_q <= '0;
    end else if (poll_q == POLL_LAST) begin
      poll_q <= '0;
    end else begin
      poll_q <= poll_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (tick && EN) begin
          state_d = SETUP;
          tmr_d   = '0;
          idx_d   = '0;
        end
      end
      SETUP: begin
        if (tmr_q == SETUP_LAST) begin
          state_d = REQ;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      REQ: begin
        state_d = WAIT_HI;
        tmr_d   = '0;
      end
      WAIT_HI: begin
        if (BUSY) begin
          state_d = WAIT_LO;
        end else if (tmr_q == TMO_LAST) begin
          state_d = DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!BUSY) begin
          if (idx_q == 3'd4) begin
            state_d = DONE;
          end else begin
            state_d = GAP;
            tmr_d   = '0;
          end
        end
      end
      GAP: begin
        if (tmr_q == GAP_LAST) begin
          state_d = REQ;
          idx_d   = idx_q + 3'd1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    snd_rec = 1'b0;
    din     = 8'h00;
    ss_n    = 1'b1;
    case (state_q)
      IDLE: ss_n = 1'b1;
      REQ: begin
        ss_n    = 1'b0;
        snd_rec = 1'b1;
        din     = (idx_q == 3'd0) ? byte0_req : 8'h00;
      end
      WAIT_HI: begin
        ss_n    = 1'b0;
        snd_rec = 1'b1;
        din     = (idx_q == 3'd0) ? byte0_hold : 8'h00;
      end
      default: ss_n = 1'b0;
    endcase
  end

  // Only the bits that reach X/Y are kept for bytes 1 and 3
  always_ff @(posedge CLK) begin
    if ((state_q == WAIT_LO) && !BUSY) begin
      case (idx_q)
        3'd0: sh0_q <= DOUT;
        3'd1: sh1_q <= DOUT[1:0];
        3'd2: sh2_q <= DOUT;
        3'd3: sh3_q <= DOUT[1:0];
        default: ;
      endcase
    end
  end

  // Byte 4 comes straight from DOUT on the edge that enters DONE
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      x_q   <= '0;
      y_q   <= '0;
      btn_q <= '0;
      dv_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      dv_q <= frame_ok;
      if (frame_ok) begin
        x_q   <= {sh1_q, sh0_q};
        y_q   <= {sh3_q, sh2_q};
        btn_q <= DOUT[2:0];
        err_q <= 1'b0;
      end else if (tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign SND_REC    = snd_rec;
  assign DIN        = din;
  assign SS         = ss_n;
  assign ACTIVE     = ~ss_n;
  assign X          = x_q;
  assign Y          = y_q;
  assign BTN        = btn_q;
  assign DATA_VALID = dv_q;
  assign ERR        = err_q;

endmodule
